// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Optional leading-zero blanking in bin2bcd_seq is enabled by BIN2BCD_LZB_EN.
package bin2bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bit counter must hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bcd_dabble_digit.sv
// One double-dabble digit cell: correct the digit (add 3 when >= 5), then
// shift one bit in from below and pass the digit's top bit to the next cell.
module bcd_dabble_digit
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  input  logic                   shift_in_i,
  output logic [BCD_DIGIT_W-1:0] digit_o,
  output logic                   carry_o
);

  logic [BCD_DIGIT_W-1:0] adj;

  // Add-3 correction followed by a one-bit left shift.
  always_comb begin
    adj     = (digit_i >= BCD_DIGIT_W'(5)) ? (digit_i + BCD_DIGIT_W'(3)) : digit_i;
    digit_o = {adj[BCD_DIGIT_W-2:0], shift_in_i};
    carry_o = adj[BCD_DIGIT_W-1];
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock (double dabble).
// Valid/ready on both sides; signed inputs are converted as sign + magnitude.
// Define BIN2BCD_LZB_EN to generate the leading-zero blank mask; otherwise
// blank is tied to zero.
//
//   state    | meaning
//   ST_IDLE  | in_ready high, waiting for an input word
//   ST_SHIFT | one shift-add-3 step per cycle, WIDTH cycles
//   ST_DONE  | result presented with out_valid until out_ready
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          in_signed,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          sign,
  output logic                          overflow,
  output logic [DIGITS-1:0]             blank
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int BCD_W = BCD_DIGIT_W * DIGITS;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic [BCD_W-1:0]   digits_q, digits_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               sign_q, sign_d;
  logic               overflow_q, overflow_d;

  logic [BCD_W-1:0]   digits_shift;
  logic [DIGITS:0]    carry;
  logic               in_neg;

  // The magnitude MSB enters digit 0; each digit's top bit feeds the next.
  assign carry[0] = mag_q[WIDTH-1];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_dabble_digit u_digit (
      .digit_i    (digits_q[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .shift_in_i (carry[g]),
      .digit_o    (digits_shift[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .carry_o    (carry[g+1])
    );
  end

  assign in_neg = in_signed & in_data[WIDTH-1];

  // State and datapath registers; reset drops any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mag_q      <= '0;
      digits_q   <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
      sign_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      digits_q   <= digits_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
      sign_q     <= sign_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    digits_d   = digits_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    sign_d     = sign_q;
    overflow_d = overflow_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Two's-complement negation keeps the most negative value exact.
          mag_d    = in_neg ? (~in_data + WIDTH'(1)) : in_data;
          neg_d    = in_neg;
          digits_d = '0;
          ovf_d    = 1'b0;
          cnt_d    = CNT_W'(WIDTH);
          state_d  = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        digits_d = digits_shift;
        mag_d    = {mag_q[WIDTH-2:0], 1'b0};
        ovf_d    = ovf_q | carry[DIGITS];
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Outputs only change here, so a partial result is never visible.
          bcd_d      = digits_shift;
          sign_d     = neg_q;
          overflow_d = ovf_q | carry[DIGITS];
          state_d    = ST_DONE;
        end
      end

      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bcd_out  = bcd_q;
  assign sign     = sign_q;
  assign overflow = overflow_q;

`ifdef BIN2BCD_LZB_EN
  logic zero_run;

  // Blank every digit above the most significant nonzero one; digit 0 always shows.
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (bcd_q[BCD_DIGIT_W*i +: BCD_DIGIT_W] == '0);
      blank[i] = zero_run;
    end
  end
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed vector table, handshake and
// reset corner sequences, and random words checked against a decimal model.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_in_valid, a_in_ready, a_in_signed, a_out_valid, a_out_ready;
  logic        a_sign, a_ovf;
  logic [15:0] a_in_data;
  logic [19:0] a_bcd;
  logic [4:0]  a_blank;

  logic        b_in_valid, b_in_ready, b_in_signed, b_out_valid, b_out_ready;
  logic        b_sign, b_ovf;
  logic [15:0] b_in_data;
  logic [15:0] b_bcd;
  logic [3:0]  b_blank;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .in_signed (a_in_signed),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .bcd_out   (a_bcd),
    .sign      (a_sign),
    .overflow  (a_ovf),
    .blank     (a_blank)
  );

  bin2bcd_seq #(.WIDTH(16), .DIGITS(4)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .in_signed (b_in_signed),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .bcd_out   (b_bcd),
    .sign      (b_sign),
    .overflow  (b_ovf),
    .blank     (b_blank)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal reference: magnitude by plain arithmetic, digits by repeated /10.
  task automatic model(input logic [15:0] d, input logic s, input int nd,
                       output logic [19:0] bcd, output logic sg, output logic ov,
                       output logic [4:0] bl);
    int mag, lim, m, hi, dig;
    sg  = s & d[15];
    mag = sg ? (65536 - int'(d)) : int'(d);
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    ov  = (mag >= lim);
    m   = mag % lim;
    bcd = '0;
    hi  = 0;
    for (int i = 0; i < nd; i++) begin
      dig = m % 10;
      m   = m / 10;
      bcd[4*i +: 4] = 4'(dig);
      if (dig != 0) hi = i;
    end
    bl = '0;
`ifdef BIN2BCD_LZB_EN
    for (int i = 1; i < nd; i++) bl[i] = (i > hi);
`endif
  endtask

  // Latency counts clock edges with the accept edge as edge 1.
  task automatic conv_a(input logic [15:0] d, input logic s, output int lat);
    int n;
    n = 0;
    while (!a_in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) check("a_in_ready_timeout", a_in_ready, 1);
    a_in_data   = d;
    a_in_signed = s;
    a_in_valid  = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    lat = 1;
    while (!a_out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_a();
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    check("a_hs_valid_low", a_out_valid, 0);
    check("a_hs_ready_high", a_in_ready, 1);
  endtask

  task automatic conv_b(input logic [15:0] d, input logic s, output int lat);
    int n;
    n = 0;
    while (!b_in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) check("b_in_ready_timeout", b_in_ready, 1);
    b_in_data   = d;
    b_in_signed = s;
    b_in_valid  = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    lat = 1;
    while (!b_out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
  endtask

  typedef struct {
    logic [15:0] d;
    logic        s;
    logic [19:0] bcd;
    logic        sg;
    logic        ov;
    logic [4:0]  bl_lzb;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [19:0] e_bcd;
    logic        e_sg, e_ov;
    logic [4:0]  e_bl;
    logic [19:0] held_bcd;
    logic [15:0] d;
    logic        s;

    vecs[0] = '{16'h04D2, 1'b0, 20'h01234, 1'b0, 1'b0, 5'b10000};
    vecs[1] = '{16'hFB2E, 1'b1, 20'h01234, 1'b1, 1'b0, 5'b10000};
    vecs[2] = '{16'hFB2E, 1'b0, 20'h64302, 1'b0, 1'b0, 5'b00000};
    vecs[3] = '{16'h8000, 1'b1, 20'h32768, 1'b1, 1'b0, 5'b00000};
    vecs[4] = '{16'hFFFF, 1'b0, 20'h65535, 1'b0, 1'b0, 5'b00000};
    vecs[5] = '{16'h0000, 1'b1, 20'h00000, 1'b0, 1'b0, 5'b11110};
    vecs[6] = '{16'h0007, 1'b0, 20'h00007, 1'b0, 1'b0, 5'b11110};
    vecs[7] = '{16'hFFFF, 1'b1, 20'h00001, 1'b1, 1'b0, 5'b11110};
    vecs[8] = '{16'h7FFF, 1'b1, 20'h32767, 1'b0, 1'b0, 5'b00000};
    vecs[9] = '{16'h03E8, 1'b0, 20'h01000, 1'b0, 1'b0, 5'b10000};

    rst_n       = 1'b0;
    a_in_valid  = 1'b0; a_in_data = '0; a_in_signed = 1'b0; a_out_ready = 1'b0;
    b_in_valid  = 1'b0; b_in_data = '0; b_in_signed = 1'b0; b_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", a_in_ready, 1);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_bcd", a_bcd, 0);
    check("rst_sign", a_sign, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_blank", a_blank, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 10; i++) begin
      conv_a(vecs[i].d, vecs[i].s, lat);
      check($sformatf("vec%0d_latency", i), lat, 17);
      check($sformatf("vec%0d_bcd", i), a_bcd, vecs[i].bcd);
      check($sformatf("vec%0d_sign", i), a_sign, vecs[i].sg);
      check($sformatf("vec%0d_ovf", i), a_ovf, vecs[i].ov);
`ifdef BIN2BCD_LZB_EN
      check($sformatf("vec%0d_blank", i), a_blank, vecs[i].bl_lzb);
`else
      check($sformatf("vec%0d_blank", i), a_blank, 0);
`endif
      release_a();
    end

    // Four-digit instance: overflow boundary
    conv_b(16'h2710, 1'b0, lat);
    check("b_10000_latency", lat, 17);
    check("b_10000_bcd", b_bcd, 16'h0000);
    check("b_10000_ovf", b_ovf, 1);
    conv_b(16'h270F, 1'b0, lat);
    check("b_9999_bcd", b_bcd, 16'h9999);
    check("b_9999_ovf", b_ovf, 0);
    conv_b(16'hFFFF, 1'b0, lat);
    check("b_65535_bcd", b_bcd, 16'h5535);
    check("b_65535_ovf", b_ovf, 1);

    // Output held under back-pressure; in_valid pulses ignored
    conv_a(16'h1234, 1'b0, lat);
    check("bp_bcd", a_bcd, 20'h04660);
    held_bcd = a_bcd;
    for (int k = 0; k < 6; k++) begin
      a_in_valid = 1'b1;
      a_in_data  = 16'h0999 + 16'(k);
      @(posedge clk); #1;
      check($sformatf("bp%0d_bcd_stable", k), a_bcd, held_bcd);
      check($sformatf("bp%0d_valid", k), a_out_valid, 1);
      check($sformatf("bp%0d_in_ready", k), a_in_ready, 0);
    end
    a_in_valid = 1'b0;
    release_a();
    @(posedge clk); #1;
    check("bp_no_stale_accept", a_in_ready, 1);
    check("bp_bcd_held_idle", a_bcd, held_bcd);
    conv_a(16'h0999, 1'b0, lat);
    check("bp_next_latency", lat, 17);
    check("bp_next_bcd", a_bcd, 20'h02457);
    release_a();

    // Reset in the middle of a conversion
    conv_a(16'hFB2E, 1'b1, lat);
    release_a();
    a_in_data = 16'h8000; a_in_signed = 1'b1; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid_bcd_held", a_bcd, 20'h01234);
    check("mid_sign_held", a_sign, 1);
    check("mid_in_ready", a_in_ready, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_bcd", a_bcd, 0);
    check("arst_sign", a_sign, 0);
    check("arst_ovf", a_ovf, 0);
    check("arst_valid", a_out_valid, 0);
    check("arst_in_ready", a_in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", a_in_ready, 1);
    check("post_rst_valid", a_out_valid, 0);
    conv_a(16'h2A5F, 1'b1, lat);
    check("post_rst_latency", lat, 17);
    check("post_rst_bcd", a_bcd, 20'h10847);
    check("post_rst_sign", a_sign, 0);
    release_a();

    // Random words against the decimal model
    for (int r = 0; r < 40; r++) begin
      d = 16'($urandom);
      s = 1'($urandom_range(0, 1));
      if (r == 0) d = 16'h8001;
      model(d, s, 5, e_bcd, e_sg, e_ov, e_bl);
      conv_a(d, s, lat);
      check($sformatf("rnd%0d_latency", r), lat, 17);
      check($sformatf("rnd%0d_bcd", r), a_bcd, e_bcd);
      check($sformatf("rnd%0d_sign", r), a_sign, e_sg);
      check($sformatf("rnd%0d_ovf", r), a_ovf, e_ov);
      check($sformatf("rnd%0d_blank", r), a_blank, e_bl);
      release_a();
    end

    for (int r = 0; r < 20; r++) begin
      d = 16'($urandom);
      s = 1'($urandom_range(0, 1));
      model(d, s, 4, e_bcd, e_sg, e_ov, e_bl);
      conv_b(d, s, lat);
      check($sformatf("brnd%0d_bcd", r), b_bcd, e_bcd[15:0]);
      check($sformatf("brnd%0d_sign", r), b_sign, e_sg);
      check($sformatf("brnd%0d_ovf", r), b_ovf, e_ov);
      check($sformatf("brnd%0d_blank", r), b_blank, e_bl[3:0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
